ps2_note_decoder: RTL and testbench

Scan-code decoder that consumes validated 11-bit PS/2 frames from the keyboard receiver and turns them into piano note events. It tracks make, break (F0) and extended (E0) prefixes and maps 13 keyboard keys onto one octave plus the upper C. It applies a software octave shift and emits one-cycle `note_on` / `note_off` strobes with a note number for the tone generator downstream.

---
 rtl/ps2_note_decoder.sv | 180 ++++++++++++++++++
 tb/tb_ps2_note_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_note_decoder.sv
// PS/2 scan-code to piano note decoder: make/break/extended tracking,
// octave shift, note_on/note_off strobes. Option: PS2_TYPEMATIC_FILTER_EN.
module ps2_note_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int OCTAVE_INIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_valid,
  input  logic [10:0] frame,
  output logic        note_on,
  output logic        note_off,
  output logic [6:0]  note,
  output logic [12:0] held,
  output logic [2:0]  octave
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXT_BRK
  } state_t;

  localparam logic [7:0] C_EXT  = 8'hE0;
  localparam logic [7:0] C_BRK  = 8'hF0;
  localparam logic [7:0] C_DOWN = 8'h1A;
  localparam logic [7:0] C_UP   = 8'h22;

  state_t state_q;
  state_t state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   byte_stb;
  logic [7:0]             code;

  logic       key_hit;
  logic [3:0] key_idx;
  logic [6:0] note_val;

  logic        make_ev;
  logic        rel_ev;
  logic        up_ev;
  logic        dn_ev;

  logic        on_d;
  logic        off_d;
  logic [6:0]  note_d;
  logic [12:0] held_d;
  logic [2:0]  octave_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], frame_valid};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // frame is stable while frame_valid is high, so it is safe to
  // read it directly once the synchronised level has risen
  assign byte_stb = sync_q[SYNC_STAGES-1] & ~edge_q;
  assign code     = frame[8:1];

  always_comb begin
    key_hit = 1'b1;
    key_idx = 4'd0;
    case (code)
      8'h1C:   key_idx = 4'd0;
      8'h1D:   key_idx = 4'd1;
      8'h1B:   key_idx = 4'd2;
      8'h24:   key_idx = 4'd3;
      8'h23:   key_idx = 4'd4;
      8'h2B:   key_idx = 4'd5;
      8'h2C:   key_idx = 4'd6;
      8'h34:   key_idx = 4'd7;
      8'h35:   key_idx = 4'd8;
      8'h33:   key_idx = 4'd9;
      8'h3C:   key_idx = 4'd10;
      8'h3B:   key_idx = 4'd11;
      8'h42:   key_idx = 4'd12;
      default: key_hit = 1'b0;
    endcase
  end

  assign note_val = 7'(octave) * 7'd12 + 7'(key_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (byte_stb) begin
      case (state_q)
        S_IDLE: begin
          if (code == C_EXT) begin
            state_d = S_EXT;
          end else if (code == C_BRK) begin
            state_d = S_BRK;
          end
        end
        S_EXT: begin
          state_d = (code == C_BRK) ? S_EXT_BRK : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign make_ev = byte_stb && state_q == S_IDLE && key_hit;
  assign rel_ev  = byte_stb && state_q == S_BRK && key_hit;
  assign up_ev   = byte_stb && state_q == S_IDLE && code == C_UP;
  assign dn_ev   = byte_stb && state_q == S_IDLE && code == C_DOWN;

  always_comb begin
    on_d     = 1'b0;
    off_d    = 1'b0;
    note_d   = note;
    held_d   = held;
    octave_d = octave;
    unique case (1'b1)
      make_ev: begin
        held_d[key_idx] = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (!held[key_idx]) begin
          note_d = note_val;
          on_d   = 1'b1;
        end
`else
        note_d = note_val;
        on_d   = 1'b1;
`endif
      end
      rel_ev: begin
        if (held[key_idx]) begin
          held_d[key_idx] = 1'b0;
          note_d          = note_val;
          off_d           = 1'b1;
        end
      end
      // shifting only with no keys down keeps note_off matching note_on
      up_ev: begin
        if (held == '0 && octave != 3'd7) begin
          octave_d = octave + 3'd1;
        end
      end
      dn_ev: begin
        if (held == '0 && octave != 3'd0) begin
          octave_d = octave - 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      note_on  <= 1'b0;
      note_off <= 1'b0;
      note     <= '0;
      held     <= '0;
      octave   <= 3'(OCTAVE_INIT);
    end else begin
      note_on  <= on_d;
      note_off <= off_d;
      note     <= note_d;
      held     <= held_d;
      octave   <= octave_d;
    end
  end

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Scoreboard bench for ps2_note_decoder: stimulus pushes expected note
// events, a negedge monitor pops and compares on every strobe.
module tb_ps2_note_decoder;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_valid = 1'b0;
  logic [10:0] frame = '0;
  logic        note_on;
  logic        note_off;
  logic [6:0]  note;
  logic [12:0] held;
  logic [2:0]  octave;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          off;
    logic [6:0]  note;
    logic [12:0] held;
  } exp_t;

  exp_t q[$];

  ps2_note_decoder #(.SYNC_STAGES(SYNC), .OCTAVE_INIT(4)) dut (
    .clk(clk),
    .rst(rst),
    .frame_valid(frame_valid),
    .frame(frame),
    .note_on(note_on),
    .note_off(note_off),
    .note(note),
    .held(held),
    .octave(octave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (note_on && note_off) begin
        checks++;
        errors++;
        $display("FAIL both_strobes: note_on=1 note_off=1 required exclusive");
      end else if (note_on || note_off) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: on=%0b off=%0b note=%0d, none required",
                   note_on, note_off, note);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (note_off != e.off || note != e.note || held != e.held) begin
            errors++;
            $display("FAIL event: off=%0b note=%0d held=%h, required off=%0b note=%0d held=%h",
                     note_off, note, held, e.off, e.note, e.held);
          end
        end
      end
    end
  end

  function automatic logic [10:0] mk(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic push(input bit off, input int n, input int h);
    exp_t e;
    e.off  = off;
    e.note = 7'(n);
    e.held = 13'(h);
    q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input int hold = 6);
    @(posedge clk);
    #3;
    frame       = mk(b);
    frame_valid = 1'b1;
    repeat (hold) @(posedge clk);
    #3;
    frame_valid = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_held", int'(held), 0);
    chk("reset_octave", int'(octave), 4);
    chk("reset_note", int'(note), 0);
    chk("reset_strobes", int'({note_on, note_off}), 0);

    // press 1C with an edge-exact latency check
    push(0, 48, 'h0001);
    @(posedge clk);
    #3;
    frame       = mk(8'h1C);
    frame_valid = 1'b1;
    for (int k = 0; k <= SYNC + 1; k++) begin
      @(posedge clk);
      #1;
      if (k == SYNC - 1) chk("lat_before", int'(note_on), 0);
      if (k == SYNC)     chk("lat_edge", int'(note_on), 1);
      if (k == SYNC + 1) chk("lat_after", int'(note_on), 0);
    end
    #2;
    frame_valid = 1'b0;
    repeat (8) @(posedge clk);
    push(1, 48, 0);
    send(8'hF0);
    send(8'h1C);

    // auto-repeat
    push(0, 58, 'h0400);
`ifndef PS2_TYPEMATIC_FILTER_EN
    push(0, 58, 'h0400);
    push(0, 58, 'h0400);
`endif
    send(8'h3C);
    send(8'h3C);
    send(8'h3C);
    push(1, 58, 0);
    send(8'hF0);
    send(8'h3C);

    // octave saturation
    repeat (4) send(8'h22);
    chk("octave_sat_hi", int'(octave), 7);
    repeat (8) send(8'h1A);
    chk("octave_sat_lo", int'(octave), 0);
    push(0, 12, 'h1000);
    send(8'h42);
    push(1, 12, 0);
    send(8'hF0);
    send(8'h42);
    repeat (4) send(8'h22);
    chk("octave_back", int'(octave), 4);

    // shift blocked while a key is held
    push(0, 48, 'h0001);
    send(8'h1C);
    send(8'h22);
    chk("octave_blocked", int'(octave), 4);
    push(1, 48, 0);
    send(8'hF0);
    send(8'h1C);

    // extended codes never sound
    send(8'hE0);
    send(8'h1C);
    send(8'hE0);
    send(8'hF0);
    send(8'h1C);
    push(0, 48, 'h0001);
    send(8'h1C);
    push(1, 48, 0);
    send(8'hF0);
    send(8'h1C);
    send(8'hF0);
    send(8'h15);
    send(8'hF0);
    send(8'h1B);
    push(0, 49, 'h0002);
    send(8'h1D);
    push(1, 49, 0);
    send(8'hF0);
    send(8'h1D);
    chk("held_clear", int'(held), 0);

    // reset after a break prefix
    send(8'hF0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    push(0, 48, 'h0001);
    send(8'h1C);
    chk("octave_after_rst", int'(octave), 4);

    // long level produces a single strobe
    push(0, 49, 'h0003);
    send(8'h1D, 1000);
    push(1, 48, 'h0002);
    send(8'hF0);
    send(8'h1C);
    push(1, 49, 0);
    send(8'hF0);
    send(8'h1D);

    repeat (10) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
